divider_rate_ctrl: RTL and testbench
====================================

DIVIDER_RATE_CTRL -- requirements
Module: divider_rate_ctrl

Interface
REQ-001 Parameter RATE_0, default 200000, half-period of clk_out in clk_in cycles for rate code 0; SHALL be >= 1.
REQ-002 Parameter RATE_1, default 100000, half-period for rate code 1; SHALL be >= 1.
REQ-003 Parameter RATE_2, default 50000, half-period for rate code 2; SHALL be >= 1.
REQ-004 Parameter RATE_3, default 25000, half-period for rate code 3; SHALL be >= 1.
REQ-005 clk_in  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 run  input  1  level; 1 = divider running, 0 = request glitch-free stop.
REQ-008 rate_sel  input  2  requested rate code, sampled on handshake.
REQ-009 rate_valid  input  1  rate change request.
REQ-010 rate_ready  output  1  controller can accept rate_sel this cycle.
REQ-011 clk_out  output  1  divided clock, registered.
REQ-012 tick  output  1  one-cycle pulse coincident with every clk_out change.
REQ-013 busy  output  1  accepted rate change not yet applied.
REQ-014 cur_rate  output  2  rate code currently driving clk_out.

Function
REQ-015 Internal counter width SHALL be $clog2(max(RATE_k)+1); active half-period H = RATE_[cur_rate].
REQ-016 FSM states SHALL be STOPPED, RUNNING, PENDING, STOPPING.
REQ-017 Terminal count (TC) SHALL be counter == H-1 in RUNNING/PENDING/STOPPING; at TC the counter SHALL clear and clk_out SHALL invert; otherwise the counter SHALL increment and clk_out SHALL hold.
REQ-018 tick SHALL be registered and high exactly in the cycle in which clk_out holds its newly toggled value.
REQ-019 STOPPED: counter held 0, clk_out 0; run=1 -> RUNNING; first clk_out rise H cycles after run is sampled high.
REQ-020 rate_ready SHALL be 1 in STOPPED and RUNNING, 0 in PENDING and STOPPING; handshake = rate_valid & rate_ready.
REQ-021 Handshake in STOPPED: cur_rate <= rate_sel next edge; state unchanged unless run=1 in the same cycle (then RUNNING with the new rate).
REQ-022 Handshake in RUNNING: rate_sel stored as pending, busy=1, -> PENDING; old H keeps running.
REQ-023 PENDING at TC: clk_out toggles, cur_rate <= pending, counter 0, busy=0; next state RUNNING if run=1, else STOPPED if new clk_out=0, else STOPPING.
REQ-024 RUNNING with run=0: clk_out=0 -> STOPPED immediately (counter cleared, low stretched, no runt); clk_out=1 -> STOPPING.
REQ-025 STOPPING: counting continues; at TC clk_out falls -> STOPPED; run=1 before TC -> RUNNING without disturbing counter.
REQ-026 Handshake with rate_sel == cur_rate SHALL still follow REQ-021/022 (no shortcut).
REQ-027 No clk_out high or low phase SHALL ever be shorter than min(old H, new H) cycles.
REQ-028 H=1 SHALL toggle clk_out every cycle with tick held continuously high.

Reset
REQ-029 reset SHALL take priority over all inputs, including mid-phase and pending changes.
REQ-030 Reset values: state STOPPED, counter 0, clk_out 0, tick 0, busy 0, cur_rate 0, pending 0, rate_ready 1.

Verification (bench overrides RATE_0=2, RATE_1=3, RATE_2=5, RATE_3=1)
REQ-031 Reset, run=1, rate 0 -> clk_out rises 2 cycles later, period 4, tick at each edge, busy 0.
REQ-032 RUNNING rate 0, request rate 2 one cycle into high phase -> busy=1, rate_ready=0; high phase ends at 2 cycles, then phases of 5; cur_rate=2 at that edge.
REQ-033 RUNNING rate 1, run=0 with clk_out=1 at counter 0 -> STOPPING, clk_out falls after 3 cycles total, then STOPPED, counter 0.
REQ-034 STOPPED, rate_valid=1 rate_sel=3 -> accepted same cycle, cur_rate=3 next edge; run=1 -> clk_out toggles every cycle, tick stays high.
REQ-035 reset asserted mid high phase with change pending -> next edge clk_out 0, busy 0, cur_rate 0, rate_ready 1.
REQ-036 PENDING with run=0 -> new rate applied at TC, then STOPPED or STOPPING per REQ-023; no phase shorter than REQ-027.

Source files
------------

// File: rtl/divider_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : divider_rate_ctrl
// Purpose  : Glitch-free clock divider with four rates and handshaked changes.
// Revision : 1.0 - initial release
// ============================================================================
module divider_rate_ctrl #(
    parameter int RATE_0 = 200000,
    parameter int RATE_1 = 100000,
    parameter int RATE_2 = 50000,
    parameter int RATE_3 = 25000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] rate_sel,
    input  logic       rate_valid,
    output logic       rate_ready,
    output logic       clk_out,
    output logic       tick,
    output logic       busy,
    output logic [1:0] cur_rate
);

    localparam int MAX_01   = (RATE_0 > RATE_1) ? RATE_0 : RATE_1;
    localparam int MAX_23   = (RATE_2 > RATE_3) ? RATE_2 : RATE_3;
    localparam int MAX_RATE = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int CNT_W    = $clog2(MAX_RATE + 1);

    localparam logic [CNT_W-1:0] c_tc_0 = CNT_W'(RATE_0 - 1);
    localparam logic [CNT_W-1:0] c_tc_1 = CNT_W'(RATE_1 - 1);
    localparam logic [CNT_W-1:0] c_tc_2 = CNT_W'(RATE_2 - 1);
    localparam logic [CNT_W-1:0] c_tc_3 = CNT_W'(RATE_3 - 1);

    localparam logic [1:0] c_stopped  = 2'd0;
    localparam logic [1:0] c_running  = 2'd1;
    localparam logic [1:0] c_pending  = 2'd2;
    localparam logic [1:0] c_stopping = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             r_busy;
    logic [1:0]       r_rate;
    logic [1:0]       r_pend;

    logic [CNT_W-1:0] w_tc_val;
    logic             w_tc;
    logic             w_ready;
    logic             w_hs;

    always_comb begin
        w_tc_val = c_tc_0;
        case (r_rate)
            2'd0:    w_tc_val = c_tc_0;
            2'd1:    w_tc_val = c_tc_1;
            2'd2:    w_tc_val = c_tc_2;
            default: w_tc_val = c_tc_3;
        endcase
    end

    assign w_tc    = (r_state != c_stopped) && (r_cnt == w_tc_val);
    assign w_ready = (r_state == c_stopped) || (r_state == c_running);
    assign w_hs    = rate_valid && w_ready;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= c_stopped;
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_rate  <= 2'd0;
            r_pend  <= 2'd0;
        end else begin
            r_tick <= 1'b0;
            // Every active state advances the phase; branches below override.
            if (r_state != c_stopped) begin
                if (w_tc) begin
                    r_cnt  <= '0;
                    r_clk  <= ~r_clk;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            case (r_state)
                c_stopped: begin
                    r_cnt <= '0;
                    r_clk <= 1'b0;
                    if (w_hs) r_rate <= rate_sel;
                    if (run) r_state <= c_running;
                end
                c_running: begin
                    if (w_hs) begin
                        r_pend  <= rate_sel;
                        r_busy  <= 1'b1;
                        r_state <= c_pending;
                    end else if (!run && !r_clk) begin
                        // Low phase is simply stretched: stop without toggling.
                        r_cnt   <= '0;
                        r_clk   <= 1'b0;
                        r_tick  <= 1'b0;
                        r_state <= c_stopped;
                    end else if (!run) begin
                        r_state <= w_tc ? c_stopped : c_stopping;
                    end
                end
                c_pending: begin
                    if (w_tc) begin
                        r_rate <= r_pend;
                        r_busy <= 1'b0;
                        if (run)        r_state <= c_running;
                        else if (r_clk) r_state <= c_stopped;
                        else            r_state <= c_stopping;
                    end
                end
                default: begin
                    if (run)       r_state <= c_running;
                    else if (w_tc) r_state <= c_stopped;
                end
            endcase
        end
    end

    assign rate_ready = w_ready;
    assign clk_out    = r_clk;
    assign tick       = r_tick;
    assign busy       = r_busy;
    assign cur_rate   = r_rate;

endmodule
`default_nettype wire

// File: tb/tb_divider_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_rate_ctrl
// Purpose  : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_rate_ctrl;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       rate_valid = 1'b0;
    logic       rate_ready;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic [1:0] cur_rate;

    int n_vec = 0;
    int n_bad = 0;

    divider_rate_ctrl #(
        .RATE_0(2), .RATE_1(3), .RATE_2(5), .RATE_3(1)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run       (run),
        .rate_sel  (rate_sel),
        .rate_valid(rate_valid),
        .rate_ready(rate_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_rate  (cur_rate)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst;
        logic       run;
        logic       valid;
        logic [1:0] sel;
        logic       clk;
        logic       tick;
        logic       busy;
        logic [1:0] rate;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    // Reference model: tracks the output clock as phases of known length.
    logic m_clk, m_tick, m_busy;
    int   m_rate, m_pend, m_elapsed;
    bit   m_on, m_has_pend, m_halting;

    function automatic int half_len(input int r);
        case (r)
            0:       return 2;
            1:       return 3;
            2:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic bit m_ready();
        return !m_has_pend && !m_halting;
    endfunction

    function automatic void m_toggle();
        m_clk     = ~m_clk;
        m_tick    = 1'b1;
        m_elapsed = 0;
    endfunction

    function automatic void model_step(input logic r, input logic ru, input logic v,
                                       input logic [1:0] s);
        bit hs, done;
        if (r) begin
            m_clk = 0; m_tick = 0; m_busy = 0; m_rate = 0; m_pend = 0;
            m_elapsed = 0; m_on = 0; m_has_pend = 0; m_halting = 0;
            return;
        end
        hs     = v && m_ready();
        done   = m_on && (m_elapsed + 1 == half_len(m_rate));
        m_tick = 1'b0;
        if (!m_on) begin
            if (hs) m_rate = int'(s);
            if (ru) begin m_on = 1; m_elapsed = 0; end
        end else if (m_has_pend) begin
            if (done) begin
                m_toggle();
                m_rate = m_pend; m_has_pend = 0; m_busy = 0;
                if (!ru) begin
                    if (!m_clk) m_on = 0;
                    else        m_halting = 1;
                end
            end else m_elapsed++;
        end else if (m_halting) begin
            if (done) begin
                m_toggle();
                if (!ru) m_on = 0;
            end else m_elapsed++;
            if (ru || done) m_halting = 0;
        end else begin
            if (hs) begin m_pend = int'(s); m_has_pend = 1; m_busy = 1; end
            if (!hs && !ru && !m_clk) begin
                m_on = 0; m_elapsed = 0;
            end else begin
                if (done) m_toggle();
                else      m_elapsed++;
                if (!hs && !ru) begin
                    if (done) m_on = 0;
                    else      m_halting = 1;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across one rising edge, keeping the model in step.
    task automatic cyc(input logic r, input logic ru, input logic v, input logic [1:0] s);
        reset = r; run = ru; rate_valid = v; rate_sel = s;
        model_step(r, ru, v, s);
        @(posedge clk_in);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".clk_out"},    int'(clk_out),    int'(m_clk));
        chk({tag, ".tick"},       int'(tick),       int'(m_tick));
        chk({tag, ".busy"},       int'(busy),       int'(m_busy));
        chk({tag, ".cur_rate"},   int'(cur_rate),   m_rate);
        chk({tag, ".rate_ready"}, int'(rate_ready), int'(m_ready()));
    endtask

    function automatic vec_t mk(input logic r, ru, v, input logic [1:0] s,
                                input logic c, t, b, input logic [1:0] rt, input logic rd);
        vec_t x;
        x.rst = r; x.run = ru; x.valid = v; x.sel = s;
        x.clk = c; x.tick = t; x.busy = b; x.rate = rt; x.rdy = rd;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        // Start-up at rate 0, then a change to rate 2 one cycle into a high phase.
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 1,1,0,0,1));
        tbl.push_back(mk(0,1,0,0, 1,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,1,0,0,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0, 1,1,0,0,1));
        tbl.push_back(mk(0,1,1,2, 1,0,1,0,0));
        tbl.push_back(mk(0,1,0,0, 0,1,0,2,1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,0, 0,0,0,2,1));
        tbl.push_back(mk(0,1,0,0, 1,1,0,2,1));
        // Rate 1, stop requested at the start of a high phase.
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,1, 0,0,0,1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,1,1));
        tbl.push_back(mk(0,1,0,0, 1,1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 0,1,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,1));
        // Rate 3 (H=1) chosen while stopped, then a same-rate request.
        tbl.push_back(mk(1,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,1,3, 0,0,0,3,1));
        tbl.push_back(mk(0,1,0,0, 0,0,0,3,1));
        tbl.push_back(mk(0,1,0,0, 1,1,0,3,1));
        tbl.push_back(mk(0,1,0,0, 0,1,0,3,1));
        tbl.push_back(mk(0,1,0,0, 1,1,0,3,1));
        tbl.push_back(mk(0,1,0,0, 0,1,0,3,1));
        tbl.push_back(mk(0,1,1,3, 1,1,1,3,0));
        tbl.push_back(mk(0,1,0,0, 0,1,0,3,1));

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("tbl[%0d]", i);
            cyc(tbl[i].rst, tbl[i].run, tbl[i].valid, tbl[i].sel);
            chk({nm, ".clk_out"},    int'(clk_out),    int'(tbl[i].clk));
            chk({nm, ".tick"},       int'(tick),       int'(tbl[i].tick));
            chk({nm, ".busy"},       int'(busy),       int'(tbl[i].busy));
            chk({nm, ".cur_rate"},   int'(cur_rate),   int'(tbl[i].rate));
            chk({nm, ".rate_ready"}, int'(rate_ready), int'(tbl[i].rdy));
        end

        // Reset in the middle of a high phase with a change outstanding.
        cyc(1,0,0,0);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0);
        cyc(0,1,1,2);
        chk("rstpend.busy_before", int'(busy), 1);
        cyc(1,1,1,2);
        chk("rstpend.clk_out",    int'(clk_out),    0);
        chk("rstpend.busy",       int'(busy),       0);
        chk("rstpend.cur_rate",   int'(cur_rate),   0);
        chk("rstpend.rate_ready", int'(rate_ready), 1);
        chk("rstpend.tick",       int'(tick),       0);

        // Pending change with run dropped during a high phase: ends low, stopped.
        cyc(1,0,0,0);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0);
        cyc(0,0,1,2);
        chk("pendhi.busy", int'(busy), 1);
        cyc(0,0,0,0);
        chk("pendhi.clk_out",  int'(clk_out),  0);
        chk("pendhi.cur_rate", int'(cur_rate), 2);
        chk("pendhi.ready",    int'(rate_ready), 1);
        for (int i = 0; i < 3; i++) cyc(0,0,0,0);
        chk("pendhi.stays_low", int'(clk_out), 0);

        // Same during a low phase: new rate's high phase runs full length, then stop.
        cyc(1,0,0,0);
        cyc(0,1,0,0);
        cyc(0,0,1,2);
        chk("pendlo.clk_out", int'(clk_out), 0);
        cyc(0,0,0,0);
        chk("pendlo.rise",  int'(clk_out), 1);
        chk("pendlo.ready", int'(rate_ready), 0);
        len = 0;
        while (clk_out === 1'b1 && len < 20) begin
            cyc(0,0,0,0);
            len++;
        end
        chk("pendlo.high_len", len, 5);
        chk("pendlo.stop_ready", int'(rate_ready), 1);

        // Randomized traffic against the reference model.
        cyc(1,0,0,0);
        cmp_model("rnd_reset");
        for (int i = 0; i < 3000; i++) begin
            logic r, ru, v;
            logic [1:0] s;
            r  = ($urandom_range(0, 199) == 0);
            ru = (((i / 64) % 4) == 3) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 5) == 0);
            s  = 2'($urandom_range(0, 3));
            cyc(r, ru, v, s);
            cmp_model($sformatf("rnd[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
